// File: rtl/id_ex_stage.sv
// ID/EX operand stage: 32x32 register file, rs1/rs2 forwarding and the ID/EX pipeline register.
// Optional write-through bypass of the writeback port is enabled by defining WB_BYPASS_EN.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int IW  = $clog2(NREG)
) (
    input  logic            iCLK,
    input  logic            iRSTn,
    input  logic            iValid,
    input  logic            iStall,
    input  logic            iFlush,
    input  logic [IW-1:0]   iRs1,
    input  logic [IW-1:0]   iRs2,
    input  logic [XLEN-1:0] iImm,
    input  logic            iUseImm,
    input  logic [3:0]      iAluCtrl,
    input  logic [IW-1:0]   iRd,
    input  logic            iRegWrite,
    input  logic            iMemFwdEn,
    input  logic [IW-1:0]   iMemFwdRd,
    input  logic [XLEN-1:0] iMemFwdData,
    input  logic            iWbEn,
    input  logic [IW-1:0]   iWbRd,
    input  logic [XLEN-1:0] iWbData,
    output logic [XLEN-1:0] oA,
    output logic [XLEN-1:0] oB,
    output logic [XLEN-1:0] oStoreData,
    output logic [3:0]      oAluCtrl,
    output logic [IW-1:0]   oRd,
    output logic            oRegWrite,
    output logic            oValid
);

    logic [XLEN-1:0] regFile [NREG];
    logic [XLEN-1:0] rs1Val_p0;
    logic [XLEN-1:0] rs2Val_p0;
    logic [XLEN-1:0] opB_p0;

    // EX/MEM wins over WB; x0 ignores every forward.
    function automatic logic [XLEN-1:0] resolveOperand(
        input logic [IW-1:0]   rs,
        input logic [XLEN-1:0] rfVal,
        input logic            memEn,
        input logic [IW-1:0]   memRd,
        input logic [XLEN-1:0] memData,
        input logic            wbEn,
        input logic [IW-1:0]   wbRd,
        input logic [XLEN-1:0] wbData
    );
        logic [XLEN-1:0] val;
        val = rfVal;
`ifdef WB_BYPASS_EN
        if (wbEn && (wbRd == rs))
            val = wbData;
`endif
        if (memEn && (memRd == rs))
            val = memData;
        if (rs == '0)
            val = '0;
        return val;
    endfunction

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            for (int i = 0; i < NREG; i++)
                regFile[i] <= '0;
        end else if (iWbEn && (iWbRd != '0)) begin
            regFile[iWbRd] <= iWbData;
        end
    end

    // Stage p0: combinational operand resolution
    always_comb begin
        rs1Val_p0 = resolveOperand(iRs1, regFile[iRs1], iMemFwdEn, iMemFwdRd, iMemFwdData,
                                   iWbEn, iWbRd, iWbData);
        rs2Val_p0 = resolveOperand(iRs2, regFile[iRs2], iMemFwdEn, iMemFwdRd, iMemFwdData,
                                   iWbEn, iWbRd, iWbData);
        opB_p0    = iUseImm ? iImm : rs2Val_p0;
    end

    // Stage p1: ID/EX register, flush > stall > load
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            oA         <= '0;
            oB         <= '0;
            oStoreData <= '0;
            oAluCtrl   <= '0;
            oRd        <= '0;
            oRegWrite  <= 1'b0;
            oValid     <= 1'b0;
        end else if (iFlush) begin
            oA         <= '0;
            oB         <= '0;
            oStoreData <= '0;
            oAluCtrl   <= '0;
            oRd        <= '0;
            oRegWrite  <= 1'b0;
            oValid     <= 1'b0;
        end else if (!iStall) begin
            oA         <= rs1Val_p0;
            oB         <= opB_p0;
            oStoreData <= rs2Val_p0;
            oAluCtrl   <= iAluCtrl;
            oRd        <= iRd;
            oRegWrite  <= iRegWrite & iValid;
            oValid     <= iValid;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// against an array-based register model and a one-deep expected-output record.
module tb_id_ex_stage;

    logic        iCLK = 1'b0;
    logic        iRSTn;
    logic        iValid, iStall, iFlush, iUseImm, iRegWrite;
    logic [4:0]  iRs1, iRs2, iRd, iMemFwdRd, iWbRd;
    logic [31:0] iImm, iMemFwdData, iWbData;
    logic [3:0]  iAluCtrl;
    logic        iMemFwdEn, iWbEn;
    logic [31:0] oA, oB, oStoreData;
    logic [3:0]  oAluCtrl;
    logic [4:0]  oRd;
    logic        oRegWrite, oValid;

    id_ex_stage dut (
        .iCLK(iCLK), .iRSTn(iRSTn), .iValid(iValid), .iStall(iStall), .iFlush(iFlush),
        .iRs1(iRs1), .iRs2(iRs2), .iImm(iImm), .iUseImm(iUseImm), .iAluCtrl(iAluCtrl),
        .iRd(iRd), .iRegWrite(iRegWrite), .iMemFwdEn(iMemFwdEn), .iMemFwdRd(iMemFwdRd),
        .iMemFwdData(iMemFwdData), .iWbEn(iWbEn), .iWbRd(iWbRd), .iWbData(iWbData),
        .oA(oA), .oB(oB), .oStoreData(oStoreData), .oAluCtrl(oAluCtrl), .oRd(oRd),
        .oRegWrite(oRegWrite), .oValid(oValid)
    );

    always #5 iCLK = ~iCLK;

    int assertCount = 0;
    int failCount   = 0;

    // Reference state: architectural register contents and the expected ID/EX record.
    logic [31:0] mdl [32];
    logic [31:0] expA, expB, expSt;
    logic [3:0]  expCtrl;
    logic [4:0]  expRd;
    logic        expRw, expVld;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refRead(input logic [4:0] rs);
        if (rs == 0) return 32'h0;
        if (iMemFwdEn && iMemFwdRd == rs) return iMemFwdData;
`ifdef WB_BYPASS_EN
        if (iWbEn && iWbRd == rs) return iWbData;
`endif
        return mdl[rs];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        {expA, expB, expSt, expCtrl, expRd, expRw, expVld} = '0;
    endtask

    task automatic checkAll(input string tag);
        check({tag, ".A"},    oA,         expA);
        check({tag, ".B"},    oB,         expB);
        check({tag, ".St"},   oStoreData, expSt);
        check({tag, ".Ctrl"}, {28'h0, oAluCtrl},  {28'h0, expCtrl});
        check({tag, ".Rd"},   {27'h0, oRd},       {27'h0, expRd});
        check({tag, ".Rw"},   {31'h0, oRegWrite}, {31'h0, expRw});
        check({tag, ".Vld"},  {31'h0, oValid},    {31'h0, expVld});
    endtask

    // Predict, clock once, update the register model, then compare all outputs.
    task automatic step(input string tag);
        logic [31:0] r1, r2;
        r1 = refRead(iRs1);
        r2 = refRead(iRs2);
        if (iFlush) begin
            {expA, expB, expSt, expCtrl, expRd, expRw, expVld} = '0;
        end else if (!iStall) begin
            expA = r1; expB = iUseImm ? iImm : r2; expSt = r2;
            expCtrl = iAluCtrl; expRd = iRd; expRw = iRegWrite & iValid; expVld = iValid;
        end
        @(posedge iCLK);
        if (iWbEn && iWbRd != 0) mdl[iWbRd] = iWbData;
        #1;
        checkAll(tag);
    endtask

    task automatic quiet();
        {iValid, iStall, iFlush, iUseImm, iRegWrite, iMemFwdEn, iWbEn} = '0;
        {iRs1, iRs2, iRd, iMemFwdRd, iWbRd} = '0;
        {iImm, iMemFwdData, iWbData} = '0;
        iAluCtrl = '0;
    endtask

    task automatic randomInputs(input int idxMax);
        iValid = 1'($urandom); iUseImm = 1'($urandom); iRegWrite = 1'($urandom);
        iStall = ($urandom_range(0, 7) == 0); iFlush = ($urandom_range(0, 15) == 0);
        iRs1 = 5'($urandom_range(0, idxMax)); iRs2 = 5'($urandom_range(0, idxMax));
        iRd = 5'($urandom); iAluCtrl = 4'($urandom); iImm = $urandom;
        iMemFwdEn = 1'($urandom); iMemFwdRd = 5'($urandom_range(0, idxMax)); iMemFwdData = $urandom;
        iWbEn = 1'($urandom); iWbRd = 5'($urandom_range(0, idxMax)); iWbData = $urandom;
    endtask

    initial begin
        quiet();
        iRSTn = 1'b0;
        modelReset();

        // Reset held with random activity: everything stays zero.
        for (int c = 0; c < 4; c++) begin
            randomInputs(31);
            iFlush = 1'b0; iStall = 1'b0; iValid = 1'b1;
            @(posedge iCLK); #1;
            checkAll("rst_hold");
        end
        quiet();
        iRSTn = 1'b1;

        // Every register reads back zero after reset.
        for (int r = 1; r < 32; r++) begin
            iValid = 1'b1; iRs1 = 5'(r); iRs2 = 5'(r);
            step("rst_read");
            check("rst_read.Aconst", oA, 32'h0);
        end

        // Write then read.
        quiet(); iWbEn = 1'b1; iWbRd = 5'd5; iWbData = 32'h1234_5678;
        step("wr_x5");
        quiet(); iValid = 1'b1; iRs1 = 5'd5; iRs2 = 5'd0;
        step("rd_x5");
        check("rd_x5.Aconst", oA, 32'h1234_5678);
        check("rd_x5.Bconst", oB, 32'h0);

        // x0 ignores writes and forwards.
        quiet(); iValid = 1'b1; iWbEn = 1'b1; iWbRd = 5'd0; iWbData = 32'hFFFF_FFFF;
        iMemFwdEn = 1'b1; iMemFwdRd = 5'd0; iMemFwdData = 32'hAAAA_AAAA;
        step("x0_fwd");
        check("x0_fwd.Aconst", oA, 32'h0);
        quiet(); iValid = 1'b1;
        step("x0_read");
        check("x0_read.Aconst", oA, 32'h0);

        // Forward priority: EX/MEM beats WB beats file.
        quiet(); iWbEn = 1'b1; iWbRd = 5'd7; iWbData = 32'd1;
        step("x7_init");
        quiet(); iValid = 1'b1; iRs1 = 5'd7; iRs2 = 5'd7;
        iWbEn = 1'b1; iWbRd = 5'd7; iWbData = 32'd2;
        iMemFwdEn = 1'b1; iMemFwdRd = 5'd7; iMemFwdData = 32'd3;
        step("prio_mem");
        check("prio_mem.Aconst", oA, 32'd3);
        check("prio_mem.Bconst", oB, 32'd3);
        quiet(); iWbEn = 1'b1; iWbRd = 5'd7; iWbData = 32'd1;
        step("x7_reinit");
        quiet(); iValid = 1'b1; iRs1 = 5'd7; iRs2 = 5'd7;
        iWbEn = 1'b1; iWbRd = 5'd7; iWbData = 32'd2;
        step("prio_wb");
`ifdef WB_BYPASS_EN
        check("prio_wb.Aconst", oA, 32'd2);
`else
        check("prio_wb.Aconst", oA, 32'd1);
`endif

        // Immediate selects B; store data keeps rs2.
        quiet(); iValid = 1'b1; iUseImm = 1'b1; iImm = 32'hFFFF_FFF0; iRs2 = 5'd5;
        step("imm");
        check("imm.Bconst",  oB,         32'hFFFF_FFF0);
        check("imm.Stconst", oStoreData, 32'h1234_5678);

        // Stall holds, flush overrides stall.
        quiet(); iValid = 1'b1; iRd = 5'd9; iRegWrite = 1'b1; iAluCtrl = 4'hA; iRs1 = 5'd5;
        step("load9");
        for (int c = 0; c < 2; c++) begin
            randomInputs(31); iStall = 1'b1; iFlush = 1'b0;
            step("stall");
            check("stall.Rdconst", {27'h0, oRd}, 32'd9);
        end
        randomInputs(31); iStall = 1'b1; iFlush = 1'b1;
        step("flush");
        check("flush.Vldconst", {31'h0, oValid}, 32'h0);
        check("flush.Rwconst",  {31'h0, oRegWrite}, 32'h0);

        // Randomized traffic with small index range to provoke forwarding collisions.
        for (int c = 0; c < 400; c++) begin
            randomInputs(7);
            if (c == 200) begin
                iRSTn = 1'b0;
                #2;
                modelReset();
                checkAll("rst_mid");
                #1;
                iRSTn = 1'b1;
            end
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
